// File: rtl/ifu_pkg.sv
// Purpose: constants and types shared by fetch, instruction memory and decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ifu_pkg;

    // Word returned by memory for the reset PC and substituted for out-of-range fetches.
    localparam logic [31:0] HALT_WORD        = 32'hFC000000;
    localparam logic [5:0]  HALT_OPCODE      = 6'b111111;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hFFFFFFFC;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

    function automatic logic is_halt(input logic [31:0] word);
        return word[31:26] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Purpose: next-PC select (redirect target, PC+4 or hold) with word alignment of targets.
// Latency: combinational.
// Backpressure: none; the caller decides when to advance.
//
// Ports:
//   i_PC        current PC
//   i_Redirect  take i_Target (highest priority)
//   i_Target    redirect byte address, low two bits dropped
//   i_Advance   step to PC+4 (wraps mod 2^32)
//   o_Next_PC   selected next PC
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] i_PC,
    input  logic        i_Redirect,
    input  logic [31:0] i_Target,
    input  logic        i_Advance,
    output logic [31:0] o_Next_PC
);

    always_comb begin
        if (i_Redirect) begin
            o_Next_PC = i_Target & ~32'd3;
        end else if (i_Advance) begin
            o_Next_PC = i_PC + 32'd4;
        end else begin
            o_Next_PC = i_PC;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC, reads the combinational instruction memory and holds one IF/ID slot.
// Latency: 1 cycle from o_Addr to o_Instr; 1 instruction/cycle when decode is ready.
// Backpressure: o_Valid && !i_Ready freezes PC and slot; redirect overrides and flushes.
//
// Ports:
//   clk, i_Rst_n (async, active-low)
//   o_Addr / i_Instruction       memory read port (data valid in the same cycle)
//   o_Valid / i_Ready            slot handshake towards decode
//   o_Instr, o_PC, o_PC_plus4    slot contents
//   i_Redirect / i_Target        branch/jump redirect
//   o_Halted                     fetch stopped on a halt word
//   o_Fetch_Count                slot transfer counter, only with IFU_PERF_COUNT_EN defined
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned IM_WORDS = 128,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        i_Rst_n,
    output logic [31:0] o_Addr,
    input  logic [31:0] i_Instruction,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_Instr,
    output logic [31:0] o_PC,
    output logic [31:0] o_PC_plus4,
    input  logic        i_Redirect,
    input  logic [31:0] i_Target,
    output logic        o_Halted
`ifdef IFU_PERF_COUNT_EN
    ,
    output logic [31:0] o_Fetch_Count
`endif
);

    localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);

    ifu_state_t  r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_slot_pc;
    logic        r_halted;

    logic        w_take;
    logic        w_xfer;
    logic        w_redirect;
    logic        w_fetch;
    logic [31:0] w_fetch_word;
    logic        w_fetch_halt;
    logic        w_advance;
    logic [31:0] w_next_pc;

    assign w_take       = !r_valid || i_Ready;
    assign w_xfer       = r_valid && i_Ready;
    // The boot cycle only moves off RESET_PC; a redirect there is dropped.
    assign w_redirect   = i_Redirect && (r_state != BOOT);
    assign w_fetch      = (r_state == RUN) && w_take && !w_redirect;
    // Out-of-range fetches are turned into a halt; this also stops PC wrap-around.
    assign w_fetch_word = (r_pc < IM_BYTES) ? i_Instruction : HALT_WORD;
    assign w_fetch_halt = is_halt(w_fetch_word);
    // A captured halt leaves the PC pointing at the halt word.
    assign w_advance    = w_fetch && !w_fetch_halt;

    ifu_next_pc u_next_pc (
        .i_PC       (r_pc),
        .i_Redirect (w_redirect),
        .i_Target   (i_Target),
        .i_Advance  (w_advance),
        .o_Next_PC  (w_next_pc)
    );

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_instr   <= HALT_WORD;
            r_slot_pc <= RESET_PC;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_pc    <= '0;
                    r_state <= RUN;
                end
                default: begin
                    r_pc <= w_next_pc;
                    if (w_redirect) begin
                        r_valid  <= 1'b0;
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end else if (w_fetch) begin
                        r_instr   <= w_fetch_word;
                        r_slot_pc <= r_pc;
                        r_valid   <= 1'b1;
                        if (w_fetch_halt) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end else if ((r_state == HALT) && w_xfer) begin
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [31:0] r_fetch_count;

    // Counts accepted slots, including one accepted in a redirect cycle.
    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_fetch_count <= '0;
        end else if (w_xfer) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_Fetch_Count = r_fetch_count;
`endif

    assign o_Addr     = r_pc;
    assign o_Valid    = r_valid;
    assign o_Instr    = r_instr;
    assign o_PC       = r_slot_pc;
    assign o_PC_plus4 = r_slot_pc + 32'd4;
    assign o_Halted   = r_halted;

endmodule
